// File: rtl/board_io_pkg.sv
// board_io_pkg: shared font, blank pattern and key roles for the board I/O controller
package board_io_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int KEY_PAGE = 1;
  localparam int KEY_FREEZE = 2;
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_FONT[nibble];
  endfunction
endpackage

// File: rtl/board_io_ctrl_key_debounce.sv
// key_debounce: synchronises, debounces and edge-detects one active-low push-button
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic pressed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, pressed_q, pressed_d, agree, done;
  always_comb begin
    sync_d = {sync_q[0], key_n};
    agree = ~sync_q[1] == level_q;
    done = !agree && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    cnt_d = (agree || done) ? '0 : cnt_q + 1'b1;
    level_d = done ? ~level_q : level_q;
    pressed_d = done && !level_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync_q <= 2'b11;
      cnt_q <= '0;
      level_q <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      pressed_q <= pressed_d;
    end
  assign level = level_q;
  assign pressed = pressed_q;
endmodule

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: debounced keys, registered LEDs and a paged, freezable 7-segment hex view
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LEDS = 10,
  parameter int NUM_HEX = 6,
  parameter int NUM_KEYS = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  localparam int NUM_PAGES = (DATA_WIDTH + 4 * NUM_HEX - 1) / (4 * NUM_HEX),
  localparam int PAGE_W = NUM_PAGES > 1 ? $clog2(NUM_PAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [NUM_KEYS-1:0]   key_n,
  output logic [NUM_KEYS-1:0]   key_level,
  output logic [NUM_KEYS-1:0]   key_pressed,
  output logic [NUM_LEDS-1:0]   ledr,
  output logic [7*NUM_HEX-1:0]  hex_n,
  output logic [PAGE_W-1:0]     page,
  output logic                  frozen
);
  localparam int WIN_W = 4 * NUM_HEX;
  localparam int PAD_W = NUM_PAGES * WIN_W;
  logic [PAGE_W-1:0] page_q, page_d;
  logic frozen_q, frozen_d;
  logic [DATA_WIDTH-1:0] snap_q, snap_d;
  logic [NUM_LEDS-1:0] ledr_q, ledr_d;
  logic [7*NUM_HEX-1:0] hex_q, hex_d;
  logic [PAD_W-1:0] padded, shifted;
  logic [WIN_W-1:0] win;
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk(clk),
      .rst(rst),
      .key_n(key_n[k]),
      .level(key_level[k]),
      .pressed(key_pressed[k])
    );
  end
  // the snapshot is zero-padded to whole pages so the last page shows 0 beyond DATA_WIDTH
  always_comb begin
    page_d = key_pressed[KEY_PAGE] ? (page_q == PAGE_W'(NUM_PAGES - 1) ? '0 : page_q + 1'b1) : page_q;
    frozen_d = frozen_q ^ key_pressed[KEY_FREEZE];
    snap_d = frozen_q ? snap_q : data_in;
    ledr_d = snap_q[NUM_LEDS-1:0];
    padded = PAD_W'(snap_q);
    shifted = padded >> (int'(page_q) * WIN_W);
    win = shifted[WIN_W-1:0];
    hex_d = '0;
    for (int i = 0; i < NUM_HEX; i++) hex_d[7*i +: 7] = hex_to_seg(win[4*i +: 4]);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      page_q <= '0;
      frozen_q <= 1'b0;
      snap_q <= '0;
      ledr_q <= '0;
      hex_q <= {NUM_HEX{SEG_BLANK}};
    end else begin
      page_q <= page_d;
      frozen_q <= frozen_d;
      snap_q <= snap_d;
      ledr_q <= ledr_d;
      hex_q <= hex_d;
    end
  assign page = page_q;
  assign frozen = frozen_q;
  assign ledr = ledr_q;
  assign hex_n = hex_q;
endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl: directed self-checking bench for board_io_ctrl with a 4-cycle debounce
module tb_board_io_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0] key_n = 4'hF;
  logic [3:0] key_level, key_pressed;
  logic [9:0] ledr;
  logic [41:0] hex_n;
  logic [0:0] page;
  logic frozen;
  int passed = 0;
  int total = 0;
  int n;
  board_io_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .key_n(key_n),
    .key_level(key_level),
    .key_pressed(key_pressed),
    .ledr(ledr),
    .hex_n(hex_n),
    .page(page),
    .frozen(frozen)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask
  task automatic press(input int k, input int hold, output int cnt);
    cnt = 0;
    key_n[k] = 1'b0;
    repeat (hold) begin
      step(1);
      if (key_pressed[k]) cnt++;
    end
    key_n[k] = 1'b1;
    repeat (8) begin
      step(1);
      if (key_pressed[k]) cnt++;
    end
  endtask
  initial begin
    logic [6:0] pat;
    bit seen;
    step(3);
    check("rst_hex", hex_n, {42{1'b1}});
    check("rst_ledr", ledr, 0);
    check("rst_page", page, 0);
    check("rst_frozen", frozen, 0);
    check("rst_keys", {key_level, key_pressed}, 0);
    rst = 1'b1;
    step(2);
    check("zero_hex", hex_n, {6{7'h40}});
    data_in = 32'hDEAD_BEEF;
    step(1);
    check("dp_lat1", ledr, 0);
    step(1);
    check("dp_ledr", ledr, 10'h2EF);
    check("dp_hex", hex_n, {7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E});
    key_n[0] = 1'b0;
    step(5);
    check("k0_early", {key_level[0], key_pressed[0]}, 2'b00);
    step(1);
    check("k0_edge", {key_level[0], key_pressed[0]}, 2'b11);
    step(1);
    check("k0_pulse_end", {key_level[0], key_pressed[0]}, 2'b10);
    key_n[0] = 1'b1;
    step(8);
    check("k0_nocontrol", {key_level[0], page, frozen}, 3'b000);
    press(1, 8, n);
    check("pg1_pulses", n, 1);
    check("pg1_page", page, 1);
    check("pg1_hex", hex_n, {7'h40, 7'h40, 7'h40, 7'h40, 7'h21, 7'h06});
    press(1, 8, n);
    check("pg_wrap", page, 0);
    check("pg_wrap_hex", hex_n, {7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E});
    pat = 7'b0001000;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      key_n[2] = pat[i];
      step(1);
      if (key_pressed[2]) n++;
    end
    key_n[2] = 1'b1;
    repeat (8) begin
      step(1);
      if (key_pressed[2]) n++;
    end
    check("bounce_pulses", n, 0);
    check("bounce_state", {key_level[2], frozen}, 2'b00);
    press(2, 6, n);
    check("stable_pulses", n, 1);
    check("stable_frozen", frozen, 1);
    press(2, 8, n);
    check("unfrz_first", frozen, 0);
    data_in = 32'h1234_5678;
    step(2);
    press(2, 8, n);
    check("frz_pulses", n, 1);
    check("frz_on", frozen, 1);
    data_in = 32'hFFFF_FFFF;
    step(3);
    check("frz_ledr", ledr, 10'h278);
    check("frz_hex", hex_n, {7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00});
    press(1, 8, n);
    check("frz_page1_hex", hex_n, {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24});
    press(1, 8, n);
    check("frz_page0", page, 0);
    key_n[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1);
      seen = key_pressed[2];
    end
    check("unfrz_pulse_seen", seen, 1);
    step(1);
    check("unfrz_frozen", frozen, 0);
    check("unfrz_hold1", ledr, 10'h278);
    step(1);
    check("unfrz_hold2", ledr, 10'h278);
    step(1);
    check("unfrz_ledr", ledr, 10'h3FF);
    check("unfrz_hex", hex_n, {6{7'h0E}});
    key_n[2] = 1'b1;
    step(8);
    key_n[1] = 1'b0;
    step(3);
    rst = 1'b0;
    #1;
    check("mid_rst_keys", {key_level, key_pressed}, 0);
    check("mid_rst_hex", hex_n, {42{1'b1}});
    step(2);
    rst = 1'b1;
    step(5);
    check("redeb_early", {key_level[1], key_pressed[1]}, 2'b00);
    step(1);
    check("redeb_edge", {key_level[1], key_pressed[1]}, 2'b11);
    step(1);
    check("redeb_page", {page, key_pressed[1]}, 2'b10);
    key_n[1] = 1'b1;
    step(8);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
